// File: rtl/pc_stack_if.sv
// Operation bus between the CHIP-8 execute stage (master) and the PC/stack unit (slave).
// Carries the op handshake plus the architectural PC, stack pointer and fault status.
interface pc_stack_if #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 16
);
    localparam int SP_W = $clog2(DEPTH) + 1;

    logic              op_valid;
    logic              op_ready;
    logic [2:0]        op;
    logic [ADDR_W-1:0] target;
    logic [7:0]        offset;
    logic [ADDR_W-1:0] pc;
    logic [SP_W-1:0]   sp;
    logic              fault;
    logic [1:0]        fault_code;

    modport master (
        output op_valid, op, target, offset,
        input  op_ready, pc, sp, fault, fault_code
    );

    modport slave (
        input  op_valid, op, target, offset,
        output op_ready, pc, sp, fault, fault_code
    );
endinterface

// File: rtl/pc_stack_unit.sv
// CHIP-8 program counter and return-address stack unit.
// Define STACK_GUARD_EN for overflow/underflow detection with a sticky fault and HALT state.
module pc_stack_unit #(
    parameter int                ADDR_W      = 12,
    parameter int                DEPTH       = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = 12'h200,
    parameter int                INSTR_BYTES = 2
) (
    input  logic       clk,
    input  logic       reset,
    pc_stack_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int SP_W  = IDX_W + 1;

    localparam logic [2:0] OP_INC      = 3'd0;
    localparam logic [2:0] OP_SKIP     = 3'd1;
    localparam logic [2:0] OP_JUMP     = 3'd2;
    localparam logic [2:0] OP_JUMP_OFS = 3'd3;
    localparam logic [2:0] OP_CALL     = 3'd4;
    localparam logic [2:0] OP_RET      = 3'd5;

    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] STEP2 = ADDR_W'(2 * INSTR_BYTES);

`ifdef STACK_GUARD_EN
    typedef enum logic [1:0] {IDLE, CALL_WR, RET_RD, HALT} state_e;
`else
    typedef enum logic [1:0] {IDLE, CALL_WR, RET_RD} state_e;
`endif

    state_e            state, state_next;
    logic [ADDR_W-1:0] pc_q;
    logic [SP_W-1:0]   sp_q, sp_inc, sp_dec;
    logic [ADDR_W-1:0] call_target;
    logic [ADDR_W-1:0] stack_mem [DEPTH];
    logic              accept, is_call, is_ret;
    logic              overflow, underflow;

    assign accept  = bus.op_valid && (state == IDLE);
    assign is_call = accept && (bus.op == OP_CALL);
    assign is_ret  = accept && (bus.op == OP_RET);

`ifdef STACK_GUARD_EN
    logic [1:0] fault_code_q;

    assign sp_inc = sp_q + SP_W'(1);
    assign sp_dec = sp_q - SP_W'(1);
`else
    // Unguarded stack wraps modulo DEPTH; the sp MSB stays 0.
    assign sp_inc = {1'b0, sp_q[IDX_W-1:0] + IDX_W'(1)};
    assign sp_dec = {1'b0, sp_q[IDX_W-1:0] - IDX_W'(1)};
`endif

    always_comb begin
        overflow  = 1'b0;
        underflow = 1'b0;
`ifdef STACK_GUARD_EN
        overflow  = is_call && (sp_q == SP_W'(DEPTH));
        underflow = is_ret && (sp_q == '0);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (overflow || underflow) begin
`ifdef STACK_GUARD_EN
                    state_next = HALT;
`endif
                end else if (is_call) begin
                    state_next = CALL_WR;
                end else if (is_ret) begin
                    state_next = RET_RD;
                end
            end
            CALL_WR: state_next = IDLE;
            RET_RD:  state_next = IDLE;
`ifdef STACK_GUARD_EN
            HALT:    state_next = HALT;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.op_ready = (state == IDLE);
    end

    // CALL latches its target so the second cycle does not depend on the held bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            sp_q        <= '0;
            call_target <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && !overflow && !underflow) begin
                        case (bus.op)
                            OP_SKIP:     pc_q <= pc_q + STEP2;
                            OP_JUMP:     pc_q <= bus.target;
                            OP_JUMP_OFS: pc_q <= bus.target + ADDR_W'(bus.offset);
                            OP_CALL:     call_target <= bus.target;
                            OP_RET:      sp_q <= sp_dec;
                            default:     pc_q <= pc_q + STEP;
                        endcase
                    end
                end
                CALL_WR: begin
                    sp_q <= sp_inc;
                    pc_q <= call_target;
                end
                RET_RD:  pc_q <= stack_mem[sp_q[IDX_W-1:0]];
                default: ;
            endcase
        end
    end

    // Stack storage is intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && is_call && !overflow) begin
            stack_mem[sp_q[IDX_W-1:0]] <= pc_q + STEP;
        end
    end

`ifdef STACK_GUARD_EN
    always_ff @(posedge clk) begin
        if (reset)          fault_code_q <= 2'd0;
        else if (overflow)  fault_code_q <= 2'd1;
        else if (underflow) fault_code_q <= 2'd2;
    end

    assign bus.fault      = (fault_code_q != 2'd0);
    assign bus.fault_code = fault_code_q;
`else
    assign bus.fault      = 1'b0;
    assign bus.fault_code = 2'd0;
`endif

    assign bus.pc = pc_q;
    assign bus.sp = sp_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed testbench for pc_stack_unit with hand-computed expectations.
// Expectations for stack overflow/underflow follow STACK_GUARD_EN, as in the design.
module tb_pc_stack_unit;
    localparam logic [2:0] OP_INC      = 3'd0;
    localparam logic [2:0] OP_SKIP     = 3'd1;
    localparam logic [2:0] OP_JUMP     = 3'd2;
    localparam logic [2:0] OP_JUMP_OFS = 3'd3;
    localparam logic [2:0] OP_CALL     = 3'd4;
    localparam logic [2:0] OP_RET      = 3'd5;

    logic clk;
    logic reset;
    int   check_count;
    int   pass_count;

    pc_stack_if #(.ADDR_W(12), .DEPTH(16)) bus ();

    pc_stack_unit #(
        .ADDR_W(12), .DEPTH(16), .RESET_PC(12'h200), .INSTR_BYTES(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else
            pass_count++;
    endtask

    // Drive one op at the falling edge and return just after the next rising edge.
    task automatic apply_stimulus(input logic [2:0] op, input logic [11:0] target, input logic [7:0] offset);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.target   = target;
        bus.offset   = offset;
        @(posedge clk);
        #1;
    endtask

    task automatic end_stimulus();
        @(negedge clk);
        bus.op_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        bus.op_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // CALL holds the op through its busy cycle, which the unit must ignore.
    task automatic do_call(input logic [11:0] target, input logic [11:0] exp_pc, input logic [4:0] exp_sp);
        apply_stimulus(OP_CALL, target, 8'h00);
        check_output("call_busy_ready", 32'(bus.op_ready), 32'd0);
        apply_stimulus(OP_CALL, target, 8'h00);
        check_output("call_pc", 32'(bus.pc), 32'(exp_pc));
        check_output("call_sp", 32'(bus.sp), 32'(exp_sp));
        check_output("call_done_ready", 32'(bus.op_ready), 32'd1);
    endtask

    task automatic do_ret(input logic [11:0] exp_pc, input logic [4:0] exp_sp);
        apply_stimulus(OP_RET, 12'h000, 8'h00);
        check_output("ret_busy_ready", 32'(bus.op_ready), 32'd0);
        check_output("ret_sp", 32'(bus.sp), 32'(exp_sp));
        apply_stimulus(OP_RET, 12'h000, 8'h00);
        check_output("ret_pc", 32'(bus.pc), 32'(exp_pc));
        check_output("ret_done_ready", 32'(bus.op_ready), 32'd1);
    endtask

    initial begin
        check_count  = 0;
        pass_count   = 0;
        reset        = 1'b1;
        bus.op_valid = 1'b0;
        bus.op       = OP_INC;
        bus.target   = '0;
        bus.offset   = '0;

        do_reset();
        check_output("rst_pc", 32'(bus.pc), 32'h200);
        check_output("rst_sp", 32'(bus.sp), 32'd0);
        check_output("rst_fault", 32'(bus.fault), 32'd0);
        check_output("rst_fault_code", 32'(bus.fault_code), 32'd0);
        check_output("rst_ready", 32'(bus.op_ready), 32'd1);

        for (int i = 0; i < 3; i++) begin
            apply_stimulus(OP_INC, 12'h000, 8'h00);
            check_output("inc_pc", 32'(bus.pc), 32'h202 + 32'(2 * i));
            check_output("inc_ready", 32'(bus.op_ready), 32'd1);
        end
        apply_stimulus(OP_SKIP, 12'h000, 8'h00);
        check_output("skip_pc", 32'(bus.pc), 32'h20A);
        apply_stimulus(OP_JUMP, 12'h300, 8'h00);
        check_output("jump_pc", 32'(bus.pc), 32'h300);
        apply_stimulus(OP_JUMP_OFS, 12'hFF0, 8'h20);
        check_output("jump_ofs_wrap_pc", 32'(bus.pc), 32'h010);
        apply_stimulus(OP_JUMP, 12'hFFE, 8'h00);
        apply_stimulus(3'd7, 12'h000, 8'h00);
        check_output("reserved_op_wrap_pc", 32'(bus.pc), 32'h000);
        apply_stimulus(OP_JUMP, 12'h300, 8'h00);
        end_stimulus();

        do_call(12'h400, 12'h400, 5'd1);
        end_stimulus();
        do_ret(12'h302, 5'd0);
        end_stimulus();

        // Nested calls: call i jumps to 0x600+16*i and pushes the previous pc+2.
        apply_stimulus(OP_JUMP, 12'h500, 8'h00);
        end_stimulus();
        for (int i = 0; i < 16; i++) begin
`ifdef STACK_GUARD_EN
            do_call(12'h600 + 12'(16 * i), 12'h600 + 12'(16 * i), 5'(i + 1));
`else
            do_call(12'h600 + 12'(16 * i), 12'h600 + 12'(16 * i), 5'((i + 1) % 16));
`endif
            end_stimulus();
        end

`ifdef STACK_GUARD_EN
        apply_stimulus(OP_CALL, 12'h700, 8'h00);
        check_output("ovf_fault", 32'(bus.fault), 32'd1);
        check_output("ovf_fault_code", 32'(bus.fault_code), 32'd1);
        check_output("ovf_pc", 32'(bus.pc), 32'h6F0);
        check_output("ovf_sp", 32'(bus.sp), 32'd16);
        check_output("ovf_ready", 32'(bus.op_ready), 32'd0);
        apply_stimulus(OP_INC, 12'h000, 8'h00);
        apply_stimulus(OP_INC, 12'h000, 8'h00);
        check_output("halt_pc", 32'(bus.pc), 32'h6F0);
        check_output("halt_ready", 32'(bus.op_ready), 32'd0);
        end_stimulus();

        do_reset();
        apply_stimulus(OP_RET, 12'h000, 8'h00);
        check_output("unf_fault", 32'(bus.fault), 32'd1);
        check_output("unf_fault_code", 32'(bus.fault_code), 32'd2);
        check_output("unf_pc", 32'(bus.pc), 32'h200);
        check_output("unf_sp", 32'(bus.sp), 32'd0);
        apply_stimulus(OP_INC, 12'h000, 8'h00);
        check_output("unf_inc_ignored_pc", 32'(bus.pc), 32'h200);
        end_stimulus();
`else
        // Overflow overwrites stack[0]; underflow then reads stack[15].
        do_call(12'h700, 12'h700, 5'd1);
        check_output("wrap_fault", 32'(bus.fault), 32'd0);
        end_stimulus();
        do_ret(12'h6F2, 5'd0);
        end_stimulus();
        do_ret(12'h6E2, 5'd15);
        check_output("wrap_fault_code", 32'(bus.fault_code), 32'd0);
        end_stimulus();
`endif

        do_reset();
        apply_stimulus(OP_CALL, 12'h400, 8'h00);
        check_output("cwr_busy_ready", 32'(bus.op_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_output("cwr_rst_pc", 32'(bus.pc), 32'h200);
        check_output("cwr_rst_sp", 32'(bus.sp), 32'd0);
        check_output("cwr_rst_fault", 32'(bus.fault), 32'd0);
        check_output("cwr_rst_ready", 32'(bus.op_ready), 32'd1);
        @(negedge clk);
        reset        = 1'b0;
        bus.op_valid = 1'b0;
        apply_stimulus(OP_INC, 12'h000, 8'h00);
        check_output("post_rst_inc_pc", 32'(bus.pc), 32'h202);
        end_stimulus();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
